// File: rtl/fir_seq_mac.sv
`default_nettype none
// ============================================================================
// Module      : fir_seq_mac
// Description : Sequential single-MAC FIR filter. Keeps a circular sample
//               history, reads coefficients from an external combinational
//               ROM and computes one tap per clock. Handshake via
//               busy / done / overrun.
//               Optional build macro FIR_SAT_EN: clamp the output to the
//               DATA_W range instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_seq_mac #(
  parameter int DATA_W    = 18,
  parameter int COEF_W    = 18,
  parameter int NTAPS     = 65,
  parameter int ADDR_W    = 7,
  parameter int ACC_W     = 43,
  parameter int OUT_SHIFT = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              endata,
  input  logic [DATA_W-1:0] datain,
  output logic [ADDR_W-1:0] coefaddress,
  input  logic [COEF_W-1:0] coefdata,
  output logic [DATA_W-1:0] dataout,
  output logic              done,
  output logic              busy,
  output logic              overrun
);

  localparam int c_ptr_w  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int c_fill_w = $clog2(NTAPS + 1);
  localparam int c_prod_w = DATA_W + COEF_W;

  // Half-LSB of the output scale, added before the shift for round-half-up
  localparam logic [ACC_W-1:0] c_round = ACC_W'(1) << (OUT_SHIFT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_hist [NTAPS];
  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_ptr_w-1:0]  r_rptr;
  logic [ADDR_W-1:0]   r_k;
  logic [c_fill_w-1:0] r_fill;
  logic [ACC_W-1:0]    r_acc;

  logic signed [c_prod_w-1:0] w_prod;
  logic [ACC_W-1:0]           w_term;
  logic                       w_tap_valid;
  logic [DATA_W-1:0]          w_result;

  assign busy = (r_state != S_IDLE);

  // Coefficient address follows the tap counter only while accumulating
  always_comb begin
    coefaddress = '0;
    if (r_state == S_MAC) coefaddress = r_k;
  end

  // Taps beyond the number of samples seen so far contribute zero, so stale
  // history left over from before reset never leaks into a result
  assign w_tap_valid = ({1'b0, r_k} < (ADDR_W + 1)'(r_fill));
  assign w_prod      = $signed(r_hist[r_rptr]) * $signed(coefdata);
  assign w_term      = w_tap_valid ? {{(ACC_W - c_prod_w){w_prod[c_prod_w-1]}}, w_prod}
                                   : '0;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] c_out_max =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_out_min =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic signed [ACC_W-1:0] w_shift;
  assign w_shift = $signed(r_acc + c_round) >>> OUT_SHIFT;

  // Clamp the rounded result into the signed output range
  always_comb begin
    w_result = w_shift[DATA_W-1:0];
    if (w_shift > c_out_max)      w_result = c_out_max[DATA_W-1:0];
    else if (w_shift < c_out_min) w_result = c_out_min[DATA_W-1:0];
  end
`else
  // Rounded result reduced to the output width by wrapping
  assign w_result = DATA_W'($signed(r_acc + c_round) >>> OUT_SHIFT);
`endif

  // Sample history; deliberately not reset, unfilled slots are masked instead
  always_ff @(posedge clock) begin
    if (reset && (r_state == S_IDLE) && endata) r_hist[r_wptr] <= datain;
  end

  // Control FSM: accept sample, walk NTAPS taps, then publish the result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_k     <= '0;
      r_fill  <= '0;
      r_acc   <= '0;
      dataout <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (endata) begin
            r_rptr <= r_wptr;
            r_k    <= '0;
            r_acc  <= '0;
            if (r_fill != c_fill_w'(NTAPS)) r_fill <= r_fill + c_fill_w'(1);
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          overrun <= endata;
          r_acc   <= r_acc + w_term;
          r_rptr  <= (r_rptr == '0) ? c_ptr_w'(NTAPS - 1) : r_rptr - c_ptr_w'(1);
          r_k     <= r_k + ADDR_W'(1);
          if (r_k == ADDR_W'(NTAPS - 1)) r_state <= S_OUT;
        end
        S_OUT: begin
          overrun <= endata;
          dataout <= w_result;
          done    <= 1'b1;
          r_wptr  <= (r_wptr == c_ptr_w'(NTAPS - 1)) ? '0 : r_wptr + c_ptr_w'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fir_seq_mac.md
Name: fir_seq_mac

Overview:
Parametrised sequential single-MAC FIR filter, the successor to the fixed 18-bit lowpass core. It keeps an internal circular sample history and reads coefficients from an external combinational ROM. It computes one tap per clock and reports progress through busy/done/overrun handshake flags. It sits between the sample source and the downstream datapath, with the coefficient ROM supplied by the enclosing design or the bench.

Parameters:
DATA_W, 18, sample/output width, two's complement
COEF_W, 18, coefficient width, two's complement
NTAPS, 65, number of taps (history depth), >=2
ADDR_W, 7, coefaddress width, 2**ADDR_W >= NTAPS
ACC_W, 43, accumulator width (>= DATA_W+COEF_W+clog2(NTAPS))
OUT_SHIFT, 10, arithmetic right shift applied to the accumulator before output, >=1

Ports:
clock  in  1  master clock, rising edge
reset  in  1  asynchronous, active-low reset
endata  in  1  sample strobe; datain is valid in the same cycle
datain  in  DATA_W  input sample
coefaddress  out  ADDR_W  coefficient ROM address
coefdata  in  COEF_W  coefficient at coefaddress, combinational, same cycle
dataout  out  DATA_W  filtered output, registered, held between results
done  out  1  one-cycle pulse, dataout just updated
busy  out  1  high while a computation is in progress
overrun  out  1  one-cycle pulse, endata ignored because busy

Behaviour:
- Reset (reset=0, async): state IDLE; dataout=0, done=0, busy=0, overrun=0, coefaddress=0; write pointer=0; fill count=0; accumulator=0. The history array is not cleared. Reset mid-computation aborts the computation with no done pulse.
- FSM IDLE -> MAC -> OUT -> IDLE. busy = (state != IDLE).
- IDLE, endata=1 at edge E0: write datain to buf[wptr]; rptr=wptr; k=0; acc=0; fill=min(fill+1,NTAPS); go MAC.
- MAC, edges E1..E_NTAPS: coefaddress=k, decoded combinationally from the k register. If k < fill, acc += sext(buf[rptr])*sext(coefdata); otherwise the product is 0, so unfilled history reads as zero. Then rptr decrements with wrap (0 -> NTAPS-1) and k increments. At E_NTAPS, after the last tap, go OUT.
- OUT, edge E_NTAPS+1: dataout = (acc + 2**(OUT_SHIFT-1)) >>> OUT_SHIFT, reduced to DATA_W bits (rounding is half-up toward +inf). done=1 for exactly one cycle. wptr advances with wrap at NTAPS-1. Go IDLE.
- Latency: endata accepted at E0, result and done at E_NTAPS+1. Throughput is one sample per NTAPS+2 cycles. A new endata is accepted during the cycle in which done is high.
- endata while busy: sample dropped; overrun=1 for that cycle; computation unaffected.
- coefaddress=0 outside MAC.
- Accumulation wraps at ACC_W; the default widths cannot overflow.

Optional Feature:
FIR_SAT_EN
- Defined: the shifted result is clamped to [-(2**(DATA_W-1)), 2**(DATA_W-1)-1] before output.
- Undefined: the low DATA_W bits of the shifted result are taken (wrap).
- All other behaviour is identical in both builds.

Test Plan:
- Impulse with the 65-tap lowpass ROM (c0=0, c1=0x3FFFD, ..., c32=0x003FE): input 0x00400, then 64 zeros -> dataout sequence equals c0..c64 sign-reduced to 18 bits (0x00000, 0x3FFFD, 0x3FFFC, ...). Each result arrives with done exactly 66 cycles after its endata.
- Fill ramp, all coefs = 1, input constant 0x00400: n-th output = n for n=1..65, then holds at 65 (0x00041), proving zero-masking of unfilled history and pointer wrap.
- Rounding, c0=1, others 0: input 0x00200 -> 0x00001; input 0x3FE00 -> 0x00000; input 0x001FF -> 0x00000.
- Overrun: endata pulsed 5 cycles after acceptance -> overrun high for that one cycle. Next result matches a run without the extra pulse, and fill increments only once.
- Saturation, all coefs 0x1FFFF, input 0x1FFFF repeated 65 times -> with FIR_SAT_EN, dataout = 0x1FFFF. Without it, dataout equals the low 18 bits of the shifted sum.
- Reset mid-MAC: reset low at cycle 20 of a computation -> busy=0, dataout=0, no done pulse. A following impulse test reproduces c0..c64 from the start.
